// File: rtl/div_unit_pkg.sv
// Shared execute-stage constants for the M-extension divider: widths, opcodes,
// FSM state encoding and the conditional two's-complement helper.
package div_unit_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic en);
    logic [XLEN-1:0] r;
    if (en) begin
      r = ~v + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// One combinational restoring-division iteration; width is a parameter so the
// step can be exercised exhaustively at small W.
module div_step
  import div_unit_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] sq,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] sq_next
);

  logic [W-1:0] low;
  logic [W:0]   diff;
  logic         ge;

  // Partial remainder is {rem, sq msb}; when rem's top bit is set the partial
  // exceeds any divisor, otherwise the borrow of the (W+1)-bit subtract decides.
  always_comb begin
    low      = {rem[W-2:0], sq[W-1]};
    diff     = {1'b0, low} - {1'b0, divisor};
    ge       = rem[W-1] | ~diff[W];
    rem_next = ge ? diff[W-1:0] : low;
    sq_next  = {sq[W-2:0], ge};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with a
// valid/ready handshake back to the execute stage.
module div_unit
  import div_unit_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  input  logic            i_kill,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam logic [XLEN-1:0]  INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ALL_ONE = {XLEN{1'b1}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);

  logic [1:0]       state_r, state_nxt;
  logic [CNT_W-1:0] cnt_r;
  logic [XLEN-1:0]  rem_r, sq_r, dvsr_r, result_r;
  logic [XLEN-1:0]  rem_nxt, sq_nxt, abs_a, abs_b, fixed;
  logic             rem_sel_r, qsign_r, rsign_r, valid_r;
  logic             accept, is_signed, div_zero, ovf, special, done_fire;

  div_step #(.W(XLEN)) u_step (
    .rem      (rem_r),
    .sq       (sq_r),
    .divisor  (dvsr_r),
    .rem_next (rem_nxt),
    .sq_next  (sq_nxt)
  );

  // Request decode: acceptance, corner-case detection, operand magnitudes
  always_comb begin
    accept    = (state_r == ST_IDLE) && i_valid && !i_kill;
    is_signed = ~i_op[0];
    div_zero  = (i_op2 == {XLEN{1'b0}});
    ovf       = is_signed && (i_op1 == INT_MIN) && (i_op2 == ALL_ONE);
    special   = div_zero || ovf;
    abs_a     = neg_if(i_op1, is_signed & i_op1[XLEN-1]);
    abs_b     = neg_if(i_op2, is_signed & i_op2[XLEN-1]);
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = special ? ST_DONE : ST_CALC;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (i_kill) begin
          state_nxt = ST_IDLE;
        end else if (cnt_r == LAST) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_CALC;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode; a flush during DONE suppresses the result pulse
  always_comb begin
    o_ready   = (state_r == ST_IDLE);
    done_fire = (state_r == ST_DONE) && !i_kill;
    fixed     = rem_sel_r ? neg_if(rem_r, rsign_r) : neg_if(sq_r, qsign_r);
  end

  // Datapath: operand capture, iteration, registered result
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_r     <= {CNT_W{1'b0}};
      rem_r     <= {XLEN{1'b0}};
      sq_r      <= {XLEN{1'b0}};
      dvsr_r    <= {XLEN{1'b0}};
      rem_sel_r <= 1'b0;
      qsign_r   <= 1'b0;
      rsign_r   <= 1'b0;
      valid_r   <= 1'b0;
      result_r  <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept) begin
            rem_sel_r <= i_op[1];
            cnt_r     <= {CNT_W{1'b0}};
            dvsr_r    <= abs_b;
            if (special) begin
              // Corner results are final as stored, so no sign fix-up
              sq_r    <= div_zero ? ALL_ONE : INT_MIN;
              rem_r   <= div_zero ? i_op1 : {XLEN{1'b0}};
              qsign_r <= 1'b0;
              rsign_r <= 1'b0;
            end else begin
              sq_r    <= abs_a;
              rem_r   <= {XLEN{1'b0}};
              qsign_r <= is_signed & (i_op1[XLEN-1] ^ i_op2[XLEN-1]);
              rsign_r <= is_signed & i_op1[XLEN-1];
            end
          end
        end
        ST_CALC: begin
          rem_r <= rem_nxt;
          sq_r  <= sq_nxt;
          cnt_r <= (cnt_r == LAST) ? {CNT_W{1'b0}} : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
      valid_r <= done_fire;
      if (done_fire) begin
        result_r <= fixed;
      end
    end
  end

  assign o_valid  = valid_r;
  assign o_result = result_r;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed RV32M corner cases plus random
// operations checked against a plain-arithmetic reference model.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_op;
  logic [31:0] i_op1;
  logic [31:0] i_op2;
  logic        i_kill;
  logic        o_valid;
  logic [31:0] o_result;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   errors   = 0;
  int   checks   = 0;
  int   edge_cnt = 0;

  div_unit dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_op1    (i_op1),
    .i_op2    (i_op2),
    .i_kill   (i_kill),
    .o_valid  (o_valid),
    .o_result (o_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (!op[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every result pulse must match the oldest pending request
  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: o_valid=1 with result %h, required no pulse", o_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", o_result, e.res);
        chk("latency", 32'(edge_cnt - e.acc), 32'(e.lat));
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold);
    int   waits;
    exp_t e;
    waits = 0;
    @(negedge clk);
    i_valid = 1'b1;
    i_op    = op;
    i_op1   = a;
    i_op2   = b;
    while (o_ready !== 1'b1 && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (o_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: o_ready=%b required 1", o_ready);
      i_valid = 1'b0;
    end else begin
      e.res = model(op, a, b);
      e.lat = is_special(op, a, b) ? 1 : 33;
      e.acc = edge_cnt + 1;
      sb.push_back(e);
      @(posedge clk);
      if (!hold) begin
        @(negedge clk);
        i_valid = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'd0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'($urandom_range(0, 20));
      4:       v = 32'd0 - 32'($urandom_range(1, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    i_valid = 1'b0;
    i_kill  = 1'b0;
    i_op    = 2'b00;
    i_op1   = 32'd0;
    i_op2   = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(o_ready), 32'd1);
    chk("reset_valid", 32'(o_valid), 32'd0);
    chk("reset_result", o_result, 32'd0);
    rst = 1'b0;

    // Basic unsigned and signed sign combinations, back-to-back with valid held
    issue(2'b01, 32'd100, 32'd7, 1'b1);
    issue(2'b11, 32'd100, 32'd7, 1'b1);
    issue(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(2'b00, 32'd7, 32'hFFFF_FFFE, 1'b1);
    issue(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0);
    drain();

    // Divide by zero, signed overflow, large unsigned
    issue(2'b00, 32'd5, 32'd0, 1'b0);
    issue(2'b11, 32'd5, 32'd0, 1'b0);
    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0010, 1'b1);
    issue(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 1'b0);
    drain();

    // Flush in IDLE blocks acceptance
    @(negedge clk);
    i_valid = 1'b1;
    i_kill  = 1'b1;
    i_op    = 2'b01;
    i_op1   = 32'd9;
    i_op2   = 32'd3;
    @(negedge clk);
    chk("kill_idle_ready", 32'(o_ready), 32'd1);
    i_valid = 1'b0;
    i_kill  = 1'b0;

    // Flush in DONE suppresses the pulse
    issue(2'b01, 32'd5, 32'd0, 1'b0);
    i_kill = 1'b1;
    @(negedge clk);
    i_kill = 1'b0;
    chk("kill_done_valid", 32'(o_valid), 32'd0);
    chk("kill_done_ready", 32'(o_ready), 32'd1);
    sb.delete();

    // Flush at CALC cycle 10, then a fresh request completes normally
    issue(2'b01, 32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    i_kill = 1'b1;
    @(negedge clk);
    i_kill = 1'b0;
    chk("kill_calc_ready", 32'(o_ready), 32'd1);
    chk("kill_calc_valid", 32'(o_valid), 32'd0);
    sb.delete();
    issue(2'b01, 32'd100, 32'd7, 1'b0);
    drain();

    // Asynchronous reset between edges mid-CALC
    issue(2'b00, 32'hFFFF_FF00, 32'd13, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(o_ready), 32'd1);
    chk("rst_mid_valid", 32'(o_valid), 32'd0);
    chk("rst_mid_result", o_result, 32'd0);
    #1;
    rst = 1'b0;
    sb.delete();
    repeat (40) @(negedge clk);
    issue(2'b11, 32'd100, 32'd7, 1'b0);
    drain();

    // Randomized operations with occasional held valid
    for (int k = 0; k < 40; k++) begin
      issue(2'($urandom_range(0, 3)), pick(), pick(), (k != 39) && ($urandom_range(0, 1) == 1));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
